// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz raster timing generator: pixel position, syncs, active flag,
// frame markers, a look-ahead memory fetch position and a per-N-frame game tick.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int LEAD     = 2,
    parameter int TICK_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       HSync,
    output logic       VSync,
    output logic       active,
    output logic       frame_start,
    output logic [9:0] fetch_col,
    output logic [9:0] fetch_row,
    output logic       re,
    output logic       game_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] LEAD_COL = 10'(LEAD);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    function automatic logic hsyncLevel(input logic [9:0] c);
        return !((c >= HS_START) && (c < HS_END));
    endfunction

    function automatic logic vsyncLevel(input logic [9:0] r);
        return !((r >= VS_START) && (r < VS_END));
    endfunction

    function automatic logic isActive(input logic [9:0] c, input logic [9:0] r);
        return (c < H_ACT) && (r < V_ACT);
    endfunction

    logic [9:0]    col_q, col_d, row_q, row_d;
    logic [9:0]    fetchCol_q, fetchCol_d, fetchRow_q, fetchRow_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          active_q, active_d, re_q, re_d;
    logic          frameStart_q, frameStart_d, gameTick_q, gameTick_d;
    logic [TW-1:0] tickCnt_q, tickCnt_d;
    logic          colWrap, fetchWrap, vblankStart, tickWrap;

    // Flags decode the counters' next values so they line up with the registered position.
    always_comb begin
        colWrap    = (col_q == H_LAST);
        col_d      = colWrap ? 10'd0 : col_q + 10'd1;
        row_d      = row_q;
        if (colWrap) begin
            row_d = (row_q == V_LAST) ? 10'd0 : row_q + 10'd1;
        end

        fetchWrap  = (fetchCol_q == H_LAST);
        fetchCol_d = fetchWrap ? 10'd0 : fetchCol_q + 10'd1;
        fetchRow_d = fetchRow_q;
        if (fetchWrap) begin
            fetchRow_d = (fetchRow_q == V_LAST) ? 10'd0 : fetchRow_q + 10'd1;
        end

        hsync_d      = hsyncLevel(col_d);
        vsync_d      = vsyncLevel(row_d);
        active_d     = isActive(col_d, row_d);
        re_d         = isActive(fetchCol_d, fetchRow_d);
        frameStart_d = (col_d == 10'd0) && (row_d == 10'd0);

        vblankStart = (col_d == 10'd0) && (row_d == V_ACT);
        tickWrap    = (tickCnt_q == TICK_LAST);
        tickCnt_d   = tickCnt_q;
        gameTick_d  = 1'b0;
        if (vblankStart) begin
            tickCnt_d  = tickWrap ? '0 : tickCnt_q + TW'(1);
            gameTick_d = tickWrap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= 10'd0;
            row_q        <= 10'd0;
            fetchCol_q   <= LEAD_COL;
            fetchRow_q   <= 10'd0;
            hsync_q      <= hsyncLevel(10'd0);
            vsync_q      <= vsyncLevel(10'd0);
            active_q     <= isActive(10'd0, 10'd0);
            re_q         <= isActive(LEAD_COL, 10'd0);
            frameStart_q <= 1'b0;
            gameTick_q   <= 1'b0;
            tickCnt_q    <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            fetchCol_q   <= fetchCol_d;
            fetchRow_q   <= fetchRow_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            active_q     <= active_d;
            re_q         <= re_d;
            frameStart_q <= frameStart_d;
            gameTick_q   <= gameTick_d;
            tickCnt_q    <= tickCnt_d;
        end
    end

    assign col         = col_q;
    assign row         = row_q;
    assign fetch_col   = fetchCol_q;
    assign fetch_row   = fetchRow_q;
    assign HSync       = hsync_q;
    assign VSync       = vsync_q;
    assign active      = active_q;
    assign re          = re_q;
    assign frame_start = frameStart_q;
    assign game_tick   = gameTick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster so many frames fit in a short run;
// the reference model tracks a linear pixel index and a count of vblank starts.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int LD = 2,  TD = 8;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int VBLANK_POS = VA * HT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] col, row, fetch_col, fetch_row;
    logic       HSync, VSync, active, frame_start, re, game_tick;
    logic [45:0] dutVec;
    logic [45:0] resetVec;

    int checks = 0;
    int errors = 0;
    int mPos = 0;
    int mVb = 0;
    logic mFs = 1'b0;
    logic mGt = 1'b0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .LEAD(LD), .TICK_DIV(TD)
    ) dut (
        .clk(clk), .reset(reset),
        .col(col), .row(row),
        .HSync(HSync), .VSync(VSync), .active(active), .frame_start(frame_start),
        .fetch_col(fetch_col), .fetch_row(fetch_row), .re(re), .game_tick(game_tick)
    );

    always #5 clk = ~clk;

    assign dutVec = {col, row, fetch_col, fetch_row, HSync, VSync, active, re, frame_start, game_tick};

    // Expected outputs are derived from the linear pixel index with plain arithmetic.
    function automatic logic [45:0] expOut();
        int c, r, fp, fc, fr;
        logic hs, vs, act, rd;
        c  = mPos % HT;
        r  = mPos / HT;
        fp = (mPos + LD) % FRAME;
        fc = fp % HT;
        fr = fp / HT;
        hs  = !((c >= HA + HF) && (c < HA + HF + HS));
        vs  = !((r >= VA + VF) && (r < VA + VF + VS));
        act = (c < HA) && (r < VA);
        rd  = (fc < HA) && (fr < VA);
        return {10'(c), 10'(r), 10'(fc), 10'(fr), hs, vs, act, rd, mFs, mGt};
    endfunction

    // One clock edge: the model follows the reset level seen at that edge.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            mPos = 0;
            mVb  = 0;
            mFs  = 1'b0;
            mGt  = 1'b0;
        end else begin
            mPos = (mPos + 1) % FRAME;
            mFs  = (mPos == 0);
            mGt  = 1'b0;
            if (mPos == VBLANK_POS) begin
                mVb = mVb + 1;
                mGt = (mVb % TD == 0);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dutVec !== resetVec) begin
                errors++;
                $display("FAIL reset_state cycle %0d got %h want %h", i, dutVec, resetVec);
            end
        end
        reset = 1'b0;
        step();
        checks++;
        if (col !== 10'd1 || row !== 10'd0) begin
            errors++;
            $display("FAIL first_release got col %0d row %0d want col 1 row 0", col, row);
        end
    endtask

    task automatic test_hsync_window();
        logic [2:0] want;
        int c;
        while (mPos < HT - 1) begin
            step();
            c = mPos % HT;
            want = {!((c >= HA + HF) && (c < HA + HF + HS)), (c < HA), (row == 10'd0)};
            checks++;
            if ({HSync, active, row == 10'd0} !== want || col !== 10'(c)) begin
                errors++;
                $display("FAIL hsync_window col %0d got hs/act/row0 %b want %b", col, {HSync, active, row == 10'd0}, want);
            end
        end
    endtask

    task automatic test_frames();
        int vsLow, fsCount, lin, flin;
        vsLow = 0;
        fsCount = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            checks++;
            if (dutVec !== expOut()) begin
                errors++;
                $display("FAIL frame_vec pos %0d got %h want %h", mPos, dutVec, expOut());
            end
            lin  = int'(row) * HT + int'(col);
            flin = int'(fetch_row) * HT + int'(fetch_col);
            checks++;
            if (flin !== (lin + LD) % FRAME) begin
                errors++;
                $display("FAIL fetch_invariant got %0d want %0d", flin, (lin + LD) % FRAME);
            end
            if (VSync === 1'b0) vsLow++;
            if (frame_start === 1'b1) fsCount++;
            if (mPos == FRAME - 2) begin
                checks++;
                if ({fetch_col, fetch_row, re} !== {10'd0, 10'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL fetch_wrap got %0d,%0d re %b want 0,0 re 1", fetch_col, fetch_row, re);
                end
            end
            if (mPos == (VA - 1) * HT + HA - 1) begin
                checks++;
                if ({fetch_col, fetch_row, re} !== {10'(HA + 1), 10'(VA - 1), 1'b0}) begin
                    errors++;
                    $display("FAIL fetch_edge got %0d,%0d re %b want %0d,%0d re 0", fetch_col, fetch_row, re, HA + 1, VA - 1);
                end
            end
        end
        checks++;
        if (vsLow !== 2 * VS * HT) begin
            errors++;
            $display("FAIL vsync_count got %0d want %0d", vsLow, 2 * VS * HT);
        end
        checks++;
        if (fsCount !== 2) begin
            errors++;
            $display("FAIL frame_start_count got %0d want 2", fsCount);
        end
    endtask

    task automatic test_game_tick();
        int pulses[$];
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 17 * FRAME; k++) begin
            step();
            if (game_tick === 1'b1) pulses.push_back(k);
            if (game_tick !== mGt) begin
                checks++;
                errors++;
                $display("FAIL game_tick_cycle k %0d got %b want %b", k, game_tick, mGt);
            end
        end
        checks++;
        if (pulses.size() !== 2) begin
            errors++;
            $display("FAIL game_tick_count got %0d want 2", pulses.size());
        end else begin
            checks++;
            if (pulses[0] !== 7 * FRAME + VBLANK_POS) begin
                errors++;
                $display("FAIL game_tick_first got %0d want %0d", pulses[0], 7 * FRAME + VBLANK_POS);
            end
            checks++;
            if (pulses[1] - pulses[0] !== TD * FRAME) begin
                errors++;
                $display("FAIL game_tick_spacing got %0d want %0d", pulses[1] - pulses[0], TD * FRAME);
            end
        end
    endtask

    task automatic test_mid_reset();
        int extra, k;
        bit seen;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6 * FRAME && mVb < 5; i++) step();
        extra = $urandom_range(1, FRAME - 2);
        for (int i = 0; i < extra; i++) step();
        reset = 1'b1;
        step();
        checks++;
        if (dutVec !== resetVec) begin
            errors++;
            $display("FAIL mid_reset_state got %h want %h", dutVec, resetVec);
        end
        reset = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 9 * FRAME) begin
            step();
            k++;
            if (game_tick === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || k !== 7 * FRAME + VBLANK_POS) begin
            errors++;
            $display("FAIL mid_reset_tick got %0d seen %b want %0d", k, seen, 7 * FRAME + VBLANK_POS);
        end
    endtask

    task automatic test_random_reset();
        int runLen, rstLen;
        for (int it = 0; it < 4; it++) begin
            runLen = $urandom_range(1, 2 * FRAME);
            rstLen = $urandom_range(1, 3);
            reset = 1'b0;
            for (int i = 0; i < runLen; i++) begin
                step();
                checks++;
                if (dutVec !== expOut()) begin
                    errors++;
                    $display("FAIL random_run it %0d pos %0d got %h want %h", it, mPos, dutVec, expOut());
                end
            end
            reset = 1'b1;
            for (int i = 0; i < rstLen; i++) begin
                step();
                checks++;
                if (dutVec !== expOut()) begin
                    errors++;
                    $display("FAIL random_reset it %0d got %h want %h", it, dutVec, expOut());
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        resetVec = {10'd0, 10'd0, 10'(LD), 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        test_reset();
        test_hsync_window();
        test_frames();
        test_game_tick();
        test_mid_reset();
        test_random_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
